sprite_compositor: RTL and testbench

- Parametrised, pipelined sprite layer compositor for the VGA game path; replaces the hand-unrolled per-object address and priority logic in the top level.
- For each scan pixel it generates per-sprite ROM addresses, applies colour-key transparency and fixed priority, and outputs the final pixel.
- Sprite coordinates are frame-latched (shadowed) to prevent tearing.
- Adds pixel-exact collision detection between sprite 0 (the player) and every other sprite.

---
 rtl/sprite_pkg.sv | 29 ++
 rtl/sprite_addr_gen.sv | 104 ++++++++++
 rtl/sprite_compositor.sv | 172 +++++++++++++++++
 tb/tb_sprite_compositor.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite compositor.
// Contents: default coordinate and size widths, the RGB444 pixel type,
// the transparent colour key, and a slice helper that pulls field `idx`
// of width `w` out of a packed per-sprite bus.
package sprite_pkg;

  localparam int DEF_XW      = 10;
  localparam int DEF_YW      = 9;
  localparam int DEF_DW      = 6;
  localparam int PIX_COLOR_W = 12;

  // Widest packed bus any caller hands to field_get.
  localparam int FIELD_BUS_W = 512;

  typedef logic [PIX_COLOR_W-1:0] rgb444_t;

  localparam rgb444_t PIX_COLOR_KEY = 12'h428;

  // Returns bus[idx*w +: w], zero-extended to 32 bits. Callers widen the bus
  // to FIELD_BUS_W and narrow the result back to the field width.
  function automatic logic [31:0] field_get(input logic [FIELD_BUS_W-1:0] bus,
                                            input int idx,
                                            input int w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return 32'(bus >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// One sprite channel of the compositor front end.
// Holds the frame-latched (shadow) copy of the sprite's enable, origin and
// size, tests the current scan position against the sprite rectangle and
// forms the sprite ROM address (row * width + column) one cycle later.
// Ports:
//   clk, rstn          pixel clock, asynchronous active-low reset
//   frame_start        loads the shadows from the live inputs
//   en_live..h_live    live sprite attributes
//   pix_valid/x/y      scan position
//   inside_q           registered "scan position is inside this sprite"
//   addr_q             registered ROM address (0 when not inside)
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int XW     = DEF_XW,
  parameter int YW     = DEF_YW,
  parameter int DW     = DEF_DW,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              frame_start,
  input  logic              en_live,
  input  logic [XW-1:0]     x_live,
  input  logic [YW-1:0]     y_live,
  input  logic [DW-1:0]     w_live,
  input  logic [DW-1:0]     h_live,
  input  logic              pix_valid,
  input  logic [XW-1:0]     pix_x,
  input  logic [YW-1:0]     pix_y,
  output logic              inside_q,
  output logic [ADDR_W-1:0] addr_q
);

  logic          en_sh_q, en_sh_d;
  logic [XW-1:0] x_sh_q,  x_sh_d;
  logic [YW-1:0] y_sh_q,  y_sh_d;
  logic [DW-1:0] w_sh_q,  w_sh_d;
  logic [DW-1:0] h_sh_q,  h_sh_d;

  logic              inside_d;
  logic [ADDR_W-1:0] addr_d;

  logic [XW:0]   x_end;
  logic [YW:0]   y_end;
  logic          in_x, in_y;
  logic [XW-1:0] dx;
  logic [YW-1:0] dy;

  // A pixel presented together with frame_start still sees the old shadows,
  // because the compare below reads the _q copies.
  always_comb begin
    en_sh_d = en_sh_q;
    x_sh_d  = x_sh_q;
    y_sh_d  = y_sh_q;
    w_sh_d  = w_sh_q;
    h_sh_d  = h_sh_q;
    if (frame_start) begin
      en_sh_d = en_live;
      x_sh_d  = x_live;
      y_sh_d  = y_live;
      w_sh_d  = w_live;
      h_sh_d  = h_live;
    end
  end

  // Stage A: bounds compare and address multiply-add.
  // The end coordinates carry one extra bit so a sprite hanging off the
  // right/bottom edge is clipped instead of wrapping to column/row 0.
  always_comb begin
    x_end    = {1'b0, x_sh_q} + (XW+1)'(w_sh_q);
    y_end    = {1'b0, y_sh_q} + (YW+1)'(h_sh_q);
    in_x     = (pix_x >= x_sh_q) && ({1'b0, pix_x} < x_end);
    in_y     = (pix_y >= y_sh_q) && ({1'b0, pix_y} < y_end);
    dx       = pix_x - x_sh_q;
    dy       = pix_y - y_sh_q;
    inside_d = en_sh_q & pix_valid & in_x & in_y;
    addr_d   = '0;
    if (inside_d) begin
      addr_d = ADDR_W'((32'(dy) * 32'(w_sh_q)) + 32'(dx));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_sh_q  <= 1'b0;
      x_sh_q   <= '0;
      y_sh_q   <= '0;
      w_sh_q   <= '0;
      h_sh_q   <= '0;
      inside_q <= 1'b0;
      addr_q   <= '0;
    end else begin
      en_sh_q  <= en_sh_d;
      x_sh_q   <= x_sh_d;
      y_sh_q   <= y_sh_d;
      w_sh_q   <= w_sh_d;
      h_sh_q   <= h_sh_d;
      inside_q <= inside_d;
      addr_q   <= addr_d;
    end
  end

endmodule

// File: rtl/sprite_compositor.sv
// Pipelined sprite layer compositor.
// Per scan pixel: per-sprite ROM addresses (stage A), a ROM_LAT-deep delay
// line aligning valid/inside with the returning ROM data, then colour-key
// transparency, fixed priority (higher index wins) and background fill
// (stage C). Also accumulates opaque overlaps of sprite 0 with every other
// sprite over a frame and publishes them on frame_start.
// Ports:
//   clk, rstn                 pixel clock, asynchronous active-low reset
//   frame_start               latches sprite shadows and collision flags
//   spr_en/x/y/w/h            live packed sprite attributes
//   pix_valid, pix_x, pix_y   scan position
//   spr_addr                  packed per-sprite ROM addresses (t+1)
//   spr_data, bg_data         ROM and background pixels, ROM_LAT after spr_addr
//   out_valid/pixel/hit       composited result (t+2+ROM_LAT)
//   coll_flags                previous-frame collisions with sprite 0
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int                 NUM_SPR   = 8,
  parameter int                 XW        = DEF_XW,
  parameter int                 YW        = DEF_YW,
  parameter int                 DW        = DEF_DW,
  parameter int                 ADDR_W    = 14,
  parameter int                 COLOR_W   = PIX_COLOR_W,
  parameter logic [COLOR_W-1:0] COLOR_KEY = PIX_COLOR_KEY,
  parameter int                 ROM_LAT   = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        frame_start,
  input  logic [NUM_SPR-1:0]          spr_en,
  input  logic [NUM_SPR*XW-1:0]       spr_x,
  input  logic [NUM_SPR*YW-1:0]       spr_y,
  input  logic [NUM_SPR*DW-1:0]       spr_w,
  input  logic [NUM_SPR*DW-1:0]       spr_h,
  input  logic                        pix_valid,
  input  logic [XW-1:0]               pix_x,
  input  logic [YW-1:0]               pix_y,
  output logic [NUM_SPR*ADDR_W-1:0]   spr_addr,
  input  logic [NUM_SPR*COLOR_W-1:0]  spr_data,
  input  logic [COLOR_W-1:0]          bg_data,
  output logic                        out_valid,
  output logic [COLOR_W-1:0]          out_pixel,
  output logic [NUM_SPR-1:0]          out_hit,
  output logic [NUM_SPR-1:0]          coll_flags
);

  logic [NUM_SPR-1:0] inside_p1;
  logic               vld_p1_q, vld_p1_d;

  logic               vld_dly_q [ROM_LAT];
  logic               vld_dly_d [ROM_LAT];
  logic [NUM_SPR-1:0] hit_dly_q [ROM_LAT];
  logic [NUM_SPR-1:0] hit_dly_d [ROM_LAT];

  logic [COLOR_W-1:0] data_c [NUM_SPR];
  logic               vld_c;
  logic [NUM_SPR-1:0] hit_c;
  logic [NUM_SPR-1:0] opaque_c;
  logic [NUM_SPR-1:0] contrib_c;

  logic               out_valid_q, out_valid_d;
  logic [COLOR_W-1:0] out_pixel_q, out_pixel_d;
  logic [NUM_SPR-1:0] out_hit_q,   out_hit_d;
  logic [NUM_SPR-1:0] acc_q,       acc_d;
  logic [NUM_SPR-1:0] coll_q,      coll_d;

  // Stage A: one address generator per sprite.
  for (genvar gi = 0; gi < NUM_SPR; gi++) begin : g_spr
    sprite_addr_gen #(
      .XW     (XW),
      .YW     (YW),
      .DW     (DW),
      .ADDR_W (ADDR_W)
    ) u_addr_gen (
      .clk         (clk),
      .rstn        (rstn),
      .frame_start (frame_start),
      .en_live     (spr_en[gi]),
      .x_live      (XW'(field_get(FIELD_BUS_W'(spr_x), gi, XW))),
      .y_live      (YW'(field_get(FIELD_BUS_W'(spr_y), gi, YW))),
      .w_live      (DW'(field_get(FIELD_BUS_W'(spr_w), gi, DW))),
      .h_live      (DW'(field_get(FIELD_BUS_W'(spr_h), gi, DW))),
      .pix_valid   (pix_valid),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .inside_q    (inside_p1[gi]),
      .addr_q      (spr_addr[gi*ADDR_W +: ADDR_W])
    );

    assign data_c[gi] = COLOR_W'(field_get(FIELD_BUS_W'(spr_data), gi, COLOR_W));
  end

  assign vld_p1_d = pix_valid;

  // Delay line: valid and inside flags follow the ROM read latency.
  always_comb begin
    vld_dly_d[0] = vld_p1_q;
    hit_dly_d[0] = inside_p1;
    for (int k = 1; k < ROM_LAT; k++) begin
      vld_dly_d[k] = vld_dly_q[k-1];
      hit_dly_d[k] = hit_dly_q[k-1];
    end
  end

  // Stage C: transparency, priority, background fill and collisions.
  always_comb begin
    vld_c     = vld_dly_q[ROM_LAT-1];
    hit_c     = hit_dly_q[ROM_LAT-1];
    opaque_c  = '0;
    contrib_c = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      opaque_c[i] = vld_c & hit_c[i] & (data_c[i] != COLOR_KEY);
    end

    out_valid_d = vld_c;
    out_hit_d   = opaque_c;
    out_pixel_d = '0;
    if (vld_c) begin
      out_pixel_d = bg_data;
      // Ascending scan: the highest opaque index overwrites the rest.
      for (int i = 0; i < NUM_SPR; i++) begin
        if (opaque_c[i]) out_pixel_d = data_c[i];
      end
    end

    for (int i = 1; i < NUM_SPR; i++) begin
      contrib_c[i] = opaque_c[0] & opaque_c[i];
    end

    // The contribution of the frame_start cycle itself goes into the
    // published flags, not into the freshly cleared accumulator.
    acc_d  = acc_q | contrib_c;
    coll_d = coll_q;
    if (frame_start) begin
      coll_d = acc_q | contrib_c;
      acc_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1_q <= 1'b0;
      for (int k = 0; k < ROM_LAT; k++) begin
        vld_dly_q[k] <= 1'b0;
        hit_dly_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_hit_q   <= '0;
      acc_q       <= '0;
      coll_q      <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      for (int k = 0; k < ROM_LAT; k++) begin
        vld_dly_q[k] <= vld_dly_d[k];
        hit_dly_q[k] <= hit_dly_d[k];
      end
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      out_hit_q   <= out_hit_d;
      acc_q       <= acc_d;
      coll_q      <= coll_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign out_hit    = out_hit_q;
  assign coll_flags = coll_q;

endmodule

// File: tb/tb_sprite_compositor.sv
module tb_sprite_compositor;

  localparam int NUM = 8;
  localparam int XW  = 10;
  localparam int YW  = 9;
  localparam int DW  = 6;
  localparam int AW  = 14;
  localparam int CW  = 12;

  logic              clk;
  logic              rstn;
  logic              frame_start;
  logic [NUM-1:0]    spr_en;
  logic [NUM*XW-1:0] spr_x;
  logic [NUM*YW-1:0] spr_y;
  logic [NUM*DW-1:0] spr_w;
  logic [NUM*DW-1:0] spr_h;
  logic              pix_valid;
  logic [XW-1:0]     pix_x;
  logic [YW-1:0]     pix_y;
  logic [NUM*AW-1:0] spr_addr;
  logic [NUM*CW-1:0] spr_data;
  logic [CW-1:0]     bg_data;
  logic              out_valid;
  logic [CW-1:0]     out_pixel;
  logic [NUM-1:0]    out_hit;
  logic [NUM-1:0]    coll_flags;

  logic [NUM*AW-1:0] exp_addr;

  int n_vec = 0;
  int n_err = 0;

  sprite_compositor dut (
    .clk         (clk),
    .rstn        (rstn),
    .frame_start (frame_start),
    .spr_en      (spr_en),
    .spr_x       (spr_x),
    .spr_y       (spr_y),
    .spr_w       (spr_w),
    .spr_h       (spr_h),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .spr_addr    (spr_addr),
    .spr_data    (spr_data),
    .bg_data     (bg_data),
    .out_valid   (out_valid),
    .out_pixel   (out_pixel),
    .out_hit     (out_hit),
    .coll_flags  (coll_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_spr(input int i, input logic en, input int x, input int y,
                         input int w, input int h);
    spr_en[i]          = en;
    spr_x[i*XW +: XW]  = XW'(x);
    spr_y[i*YW +: YW]  = YW'(y);
    spr_w[i*DW +: DW]  = DW'(w);
    spr_h[i*DW +: DW]  = DW'(h);
  endtask

  task automatic set_data(input int i, input logic [CW-1:0] c);
    spr_data[i*CW +: CW] = c;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Presents one pixel for one cycle; returns just after the stage-A edge.
  task automatic scan(input int x, input int y);
    pix_valid = 1'b1;
    pix_x     = XW'(x);
    pix_y     = YW'(y);
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    #2 rstn = 1'b0;
    tick();
    tick();
    n_vec++; if (spr_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %h want 0", spr_addr); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_vec++; if (out_pixel !== 12'h000) begin n_err++; $display("FAIL reset_pixel: got %h want 000", out_pixel); end
    n_vec++; if (out_hit !== 8'h00) begin n_err++; $display("FAIL reset_hit: got %h want 00", out_hit); end
    n_vec++; if (coll_flags !== 8'h00) begin n_err++; $display("FAIL reset_coll: got %h want 00", coll_flags); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    set_spr(0, 1'b1, 10, 20, 4, 3);
    pulse_frame();
    set_data(0, 12'hABC);
    bg_data = 12'h0F0;
    scan(11, 21);
    exp_addr = '0;
    exp_addr[0 +: AW] = AW'(5);
    n_vec++; if (spr_addr !== exp_addr) begin n_err++; $display("FAIL basic_addr: got %h want %h", spr_addr, exp_addr); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_latency: got valid %b at t+2 want 0", out_valid); end
    tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    n_vec++; if (out_pixel !== 12'hABC) begin n_err++; $display("FAIL basic_pixel: got %h want abc", out_pixel); end
    n_vec++; if (out_hit !== 8'h01) begin n_err++; $display("FAIL basic_hit: got %h want 01", out_hit); end
    tick();
    n_vec++; if (out_valid !== 1'b0 || out_pixel !== 12'h000) begin n_err++; $display("FAIL basic_idle: got valid %b pixel %h want 0/000", out_valid, out_pixel); end
  endtask

  task automatic test_color_key();
    set_data(0, 12'h428);
    scan(11, 21);
    tick();
    tick();
    n_vec++; if (out_pixel !== 12'h0F0) begin n_err++; $display("FAIL key_pixel: got %h want 0f0", out_pixel); end
    n_vec++; if (out_hit !== 8'h00) begin n_err++; $display("FAIL key_hit: got %h want 00", out_hit); end
    set_data(0, 12'hABC);
  endtask

  task automatic test_priority();
    set_spr(2, 1'b1, 100, 100, 8, 8);
    set_spr(5, 1'b1, 100, 100, 8, 8);
    set_data(2, 12'h111);
    set_data(5, 12'h555);
    pulse_frame();
    scan(103, 102);
    exp_addr = '0;
    exp_addr[2*AW +: AW] = AW'(19);
    exp_addr[5*AW +: AW] = AW'(19);
    n_vec++; if (spr_addr !== exp_addr) begin n_err++; $display("FAIL prio_addr: got %h want %h", spr_addr, exp_addr); end
    tick();
    tick();
    n_vec++; if (out_pixel !== 12'h555) begin n_err++; $display("FAIL prio_pixel: got %h want 555", out_pixel); end
    n_vec++; if (out_hit !== 8'b0010_0100) begin n_err++; $display("FAIL prio_hit: got %b want 00100100", out_hit); end
  endtask

  task automatic test_shadow();
    spr_x[0 +: XW] = XW'(50);
    spr_en[2] = 1'b0;
    spr_en[5] = 1'b0;
    scan(11, 21);
    exp_addr = '0;
    exp_addr[0 +: AW] = AW'(5);
    n_vec++; if (spr_addr !== exp_addr) begin n_err++; $display("FAIL shadow_hold_addr: got %h want %h", spr_addr, exp_addr); end
    tick();
    tick();
    n_vec++; if (out_hit !== 8'h01) begin n_err++; $display("FAIL shadow_hold_hit: got %h want 01", out_hit); end
    pulse_frame();
    scan(11, 21);
    n_vec++; if (spr_addr !== '0) begin n_err++; $display("FAIL shadow_moved_addr: got %h want 0", spr_addr); end
    tick();
    tick();
    n_vec++; if (out_hit !== 8'h00 || out_pixel !== 12'h0F0) begin n_err++; $display("FAIL shadow_moved_out: got hit %h pixel %h want 00/0f0", out_hit, out_pixel); end
    // Pixel presented with frame_start must use the old (x=50) shadow.
    spr_x[0 +: XW] = XW'(10);
    frame_start = 1'b1;
    scan(11, 21);
    frame_start = 1'b0;
    n_vec++; if (spr_addr !== '0) begin n_err++; $display("FAIL shadow_same_cycle: got %h want 0", spr_addr); end
    tick();
    tick();
    scan(11, 21);
    n_vec++; if (spr_addr !== exp_addr) begin n_err++; $display("FAIL shadow_reload_addr: got %h want %h", spr_addr, exp_addr); end
    tick();
    tick();
  endtask

  task automatic test_collision();
    set_spr(3, 1'b1, 10, 20, 4, 3);
    set_data(3, 12'h333);
    pulse_frame();
    n_vec++; if (coll_flags !== 8'h00) begin n_err++; $display("FAIL coll_none: got %b want 00000000", coll_flags); end
    scan(11, 21);
    tick();
    tick();
    n_vec++; if (out_pixel !== 12'h333) begin n_err++; $display("FAIL coll_pixel: got %h want 333", out_pixel); end
    n_vec++; if (out_hit !== 8'b0000_1001) begin n_err++; $display("FAIL coll_hit: got %b want 00001001", out_hit); end
    n_vec++; if (coll_flags !== 8'h00) begin n_err++; $display("FAIL coll_early: got %b want 00000000", coll_flags); end
    pulse_frame();
    n_vec++; if (coll_flags !== 8'b0000_1000) begin n_err++; $display("FAIL coll_latched: got %b want 00001000", coll_flags); end
    pulse_frame();
    n_vec++; if (coll_flags !== 8'h00) begin n_err++; $display("FAIL coll_cleared: got %b want 00000000", coll_flags); end
    // Overlap reaching stage C in the frame_start cycle.
    scan(11, 21);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_vec++; if (coll_flags !== 8'b0000_1000) begin n_err++; $display("FAIL coll_coincident: got %b want 00001000", coll_flags); end
    n_vec++; if (out_hit !== 8'b0000_1001) begin n_err++; $display("FAIL coll_coincident_hit: got %b want 00001001", out_hit); end
    pulse_frame();
    n_vec++; if (coll_flags !== 8'h00) begin n_err++; $display("FAIL coll_acc_reset: got %b want 00000000", coll_flags); end
  endtask

  task automatic test_edge();
    set_spr(6, 1'b1, 0, 0, 0, 5);
    set_spr(7, 1'b1, 1020, 0, 10, 4);
    set_data(6, 12'h666);
    set_data(7, 12'h777);
    pulse_frame();
    scan(2, 1);
    n_vec++; if (spr_addr !== '0) begin n_err++; $display("FAIL edge_nowrap_addr: got %h want 0", spr_addr); end
    tick();
    tick();
    n_vec++; if (out_hit !== 8'h00 || out_pixel !== 12'h0F0) begin n_err++; $display("FAIL edge_nowrap_out: got hit %h pixel %h want 00/0f0", out_hit, out_pixel); end
    scan(0, 0);
    tick();
    tick();
    n_vec++; if (out_hit !== 8'h00) begin n_err++; $display("FAIL edge_zero_width: got %h want 00", out_hit); end
    scan(1022, 1);
    exp_addr = '0;
    exp_addr[7*AW +: AW] = AW'(12);
    n_vec++; if (spr_addr !== exp_addr) begin n_err++; $display("FAIL edge_right_addr: got %h want %h", spr_addr, exp_addr); end
    tick();
    tick();
    n_vec++; if (out_hit !== 8'h80 || out_pixel !== 12'h777) begin n_err++; $display("FAIL edge_right_out: got hit %h pixel %h want 80/777", out_hit, out_pixel); end
  endtask

  task automatic test_async_reset();
    pix_valid = 1'b1;
    pix_x     = XW'(11);
    pix_y     = YW'(21);
    tick();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre_valid: got %b want 1", out_valid); end
    n_vec++; if (coll_flags !== 8'b0000_1000) begin n_err++; $display("FAIL arst_pre_coll: got %b want 00001000", coll_flags); end
    #2 rstn = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", out_valid); end
    n_vec++; if (out_pixel !== 12'h000) begin n_err++; $display("FAIL arst_pixel: got %h want 000", out_pixel); end
    n_vec++; if (coll_flags !== 8'h00) begin n_err++; $display("FAIL arst_coll: got %b want 00000000", coll_flags); end
    n_vec++; if (spr_addr !== '0) begin n_err++; $display("FAIL arst_addr: got %h want 0", spr_addr); end
    #3 rstn = 1'b1;
    tick();
    tick();
    tick();
    tick();
    // Shadows were cleared, so a valid pixel now shows only background.
    n_vec++; if (out_valid !== 1'b1 || out_hit !== 8'h00 || out_pixel !== 12'h0F0) begin n_err++; $display("FAIL arst_shadow_clear: got valid %b hit %h pixel %h want 1/00/0f0", out_valid, out_hit, out_pixel); end
    pix_valid = 1'b0;
    tick();
  endtask

  initial begin
    frame_start = 1'b0;
    spr_en      = '0;
    spr_x       = '0;
    spr_y       = '0;
    spr_w       = '0;
    spr_h       = '0;
    pix_valid   = 1'b0;
    pix_x       = '0;
    pix_y       = '0;
    spr_data    = '0;
    bg_data     = 12'h0F0;
    exp_addr    = '0;
    test_reset();
    test_basic();
    test_color_key();
    test_priority();
    test_shadow();
    test_collision();
    test_edge();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
